// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate cache.
// CPU side moves 32-bit words; memory side moves 128-bit (4-word) lines.
// One request is in flight at a time. A hit completes in the cycle after
// acceptance. A miss may first write back a dirty victim, then fills the line
// and re-runs the lookup, which then completes with hit=0.
// Optional feature macro: DM_CACHE_PERF_EN adds hit_cnt/miss_cnt counters.
module dm_cache #(
  parameter int LINES = 256
) (
  input  logic         clk,
  input  logic         r,
  input  logic         cpu2cache_rw,
  input  logic         cpu2cache_valid,
  input  logic [31:0]  cpu2cache_addr,
  input  logic [31:0]  cpu2cache_data,
  output logic         cache2cpu_ready,
  output logic         cache2cpu_hit,
  output logic [31:0]  cache2cpu_data,
  output logic         cache2mem_rw,
  output logic         cache2mem_valid,
  output logic [31:0]  cache2mem_addr,
  output logic [127:0] cache2mem_data,
  input  logic         mem2cache_ready,
  input  logic [127:0] mem2cache_data
`ifdef DM_CACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COMPARE    = 2'd1,
    S_WRITE_BACK = 2'd2,
    S_ALLOCATE   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   miss_q, miss_d;

  // Latched request; the byte offset bits [1:0] are never used.
  logic          rw_q;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    unused_byte_offset;

  // Per-line storage.
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_arr  [LINES];
  logic [127:0]     data_arr [LINES];

  // Memory-port hold registers (values persist outside WRITE_BACK/ALLOCATE).
  logic         mem_rw_q;
  logic [31:0]  mem_addr_q;
  logic [127:0] mem_data_q;

  // Decoded fields of the latched address and current line view.
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [1:0]    req_word;
  logic [127:0]  cur_line;
  logic          lookup_hit;
  logic          accept;
  logic          wr_hit;
  logic          fill_we;

  assign unused_byte_offset = cpu2cache_addr[1:0];

  assign req_tag    = addr_q[31:4+IW];
  assign req_idx    = addr_q[3+IW:4];
  assign req_word   = addr_q[3:2];
  assign cur_line   = data_arr[req_idx];
  assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign accept     = (state_q == S_IDLE) && cpu2cache_valid;

  // State, miss flag and memory-port hold registers.
  // NOTE: sequential state is written with non-blocking (<=) so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q    <= S_IDLE;
      miss_q     <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_data_q <= 128'h0;
    end else begin
      state_q    <= state_d;
      miss_q     <= miss_d;
      mem_rw_q   <= cache2mem_rw;
      mem_addr_q <= cache2mem_addr;
      mem_data_q <= cache2mem_data;
    end
  end

  // Capture the CPU request when it is accepted in IDLE.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      rw_q    <= cpu2cache_rw;
      addr_q  <= cpu2cache_addr[31:2];
      wdata_q <= cpu2cache_data;
    end
  end

  // Valid/dirty bits: cleared by reset, set by fill and write hits.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: written by fills and write hits.
  // NOTE: the arrays carry no reset; valid_q gates every use of their contents,
  // and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= mem2cache_data;
    end else if (wr_hit) begin
      data_arr[req_idx][32*req_word +: 32] <= wdata_q;
    end
  end

  // Next-state logic and all port outputs.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    miss_d          = miss_q;
    cache2cpu_ready = 1'b0;
    cache2cpu_hit   = 1'b0;
    cache2cpu_data  = 32'h0;
    cache2mem_valid = 1'b0;
    cache2mem_rw    = mem_rw_q;
    cache2mem_addr  = mem_addr_q;
    cache2mem_data  = mem_data_q;
    wr_hit          = 1'b0;
    fill_we         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu2cache_valid) begin
          miss_d  = 1'b0;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (lookup_hit) begin
          cache2cpu_ready = 1'b1;
          cache2cpu_hit   = !miss_q;
          if (rw_q) begin
            wr_hit = 1'b1;
          end else begin
            cache2cpu_data = cur_line[32*req_word +: 32];
          end
          state_d = S_IDLE;
        end else begin
          miss_d  = 1'b1;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITE_BACK
                                                            : S_ALLOCATE;
        end
      end

      S_WRITE_BACK: begin
        cache2mem_valid = 1'b1;
        cache2mem_rw    = 1'b1;
        cache2mem_addr  = {tag_arr[req_idx], req_idx, 4'h0};
        cache2mem_data  = cur_line;
        if (mem2cache_ready) begin
          state_d = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        cache2mem_valid = 1'b1;
        cache2mem_rw    = 1'b0;
        cache2mem_addr  = {req_tag, req_idx, 4'h0};
        if (mem2cache_ready) begin
          fill_we = 1'b1;
          state_d = S_COMPARE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef DM_CACHE_PERF_EN
  // Completion counters, split by the reported hit flag; both wrap naturally.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (cache2cpu_ready) begin
      if (cache2cpu_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: directed self-checking bench for dm_cache.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dm_cache;

  logic         clk = 1'b0;
  logic         r;
  logic         cpu2cache_rw;
  logic         cpu2cache_valid;
  logic [31:0]  cpu2cache_addr;
  logic [31:0]  cpu2cache_data;
  logic         cache2cpu_ready;
  logic         cache2cpu_hit;
  logic [31:0]  cache2cpu_data;
  logic         cache2mem_rw;
  logic         cache2mem_valid;
  logic [31:0]  cache2mem_addr;
  logic [127:0] cache2mem_data;
  logic         mem2cache_ready;
  logic [127:0] mem2cache_data;
`ifdef DM_CACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  dm_cache #(.LINES(256)) dut (
    .clk             (clk),
    .r               (r),
    .cpu2cache_rw    (cpu2cache_rw),
    .cpu2cache_valid (cpu2cache_valid),
    .cpu2cache_addr  (cpu2cache_addr),
    .cpu2cache_data  (cpu2cache_data),
    .cache2cpu_ready (cache2cpu_ready),
    .cache2cpu_hit   (cache2cpu_hit),
    .cache2cpu_data  (cache2cpu_data),
    .cache2mem_rw    (cache2mem_rw),
    .cache2mem_valid (cache2mem_valid),
    .cache2mem_addr  (cache2mem_addr),
    .cache2mem_data  (cache2mem_data),
    .mem2cache_ready (mem2cache_ready),
    .mem2cache_data  (mem2cache_data)
`ifdef DM_CACHE_PERF_EN
    ,
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; returns on the falling edge of the
  // cycle in which the DUT is in its first lookup.
  task automatic req(input logic rw, input logic [31:0] addr,
                     input logic [31:0] data);
    @(negedge clk);
    cpu2cache_rw    = rw;
    cpu2cache_addr  = addr;
    cpu2cache_data  = data;
    cpu2cache_valid = 1'b1;
    @(negedge clk);
    cpu2cache_valid = 1'b0;
    cpu2cache_data  = 32'h0;
  endtask

  // Wait (bounded) for a memory request, then check its type and address.
  task automatic wait_mem(input string tag, input logic rw,
                          input logic [31:0] addr);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cache2mem_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_req_seen"}, found, 1'b1);
    check({tag, "_rw"}, cache2mem_rw, rw);
    check({tag, "_addr"}, cache2mem_addr, addr);
  endtask

  // Pulse the memory completion for one cycle with the given line.
  task automatic respond(input logic [127:0] line);
    mem2cache_ready = 1'b1;
    mem2cache_data  = line;
    @(negedge clk);
    mem2cache_ready = 1'b0;
  endtask

  initial begin
    r               = 1'b0;
    cpu2cache_rw    = 1'b0;
    cpu2cache_valid = 1'b0;
    cpu2cache_addr  = 32'h0;
    cpu2cache_data  = 32'h0;
    mem2cache_ready = 1'b0;
    mem2cache_data  = 128'h0;

    // Reset state: every output is zero.
    repeat (3) @(negedge clk);
    check("rst_ready", cache2cpu_ready, 1'b0);
    check("rst_hit", cache2cpu_hit, 1'b0);
    check("rst_cpu_data", cache2cpu_data, 32'h0);
    check("rst_mem_valid", cache2mem_valid, 1'b0);
    check("rst_mem_rw", cache2mem_rw, 1'b0);
    check("rst_mem_addr", cache2mem_addr, 32'h0);
    check("rst_mem_data", cache2mem_data, 128'h0);
    r = 1'b1;
    @(negedge clk);

    // Read miss on a cold cache.
    req(1'b0, 32'h0000_1234, 32'h0);
    check("rdmiss_lookup_ready", cache2cpu_ready, 1'b0);
    @(negedge clk);
    wait_mem("rdmiss_alloc", 1'b0, 32'h0000_1230);
    respond({4{32'hDEAD_BEEF}});
    check("rdmiss_ready", cache2cpu_ready, 1'b1);
    check("rdmiss_hit", cache2cpu_hit, 1'b0);
    check("rdmiss_data", cache2cpu_data, 32'hDEAD_BEEF);
    check("rdmiss_mem_idle", cache2mem_valid, 1'b0);
    check("rdmiss_mem_addr_hold", cache2mem_addr, 32'h0000_1230);
    @(negedge clk);
    check("idle_ready", cache2cpu_ready, 1'b0);
    check("idle_cpu_data", cache2cpu_data, 32'h0);

    // Read hit, one cycle after acceptance.
    req(1'b0, 32'h0000_1234, 32'h0);
    check("rdhit_ready", cache2cpu_ready, 1'b1);
    check("rdhit_hit", cache2cpu_hit, 1'b1);
    check("rdhit_data", cache2cpu_data, 32'hDEAD_BEEF);
    check("rdhit_no_mem", cache2mem_valid, 1'b0);

    // Write miss: allocate, then merge the write into the filled line.
    req(1'b1, 32'h0000_5678, 32'hCAFE_BABE);
    check("wrmiss_lookup_ready", cache2cpu_ready, 1'b0);
    @(negedge clk);
    wait_mem("wrmiss_alloc", 1'b0, 32'h0000_5670);
    respond({4{32'hFEED_FACE}});
    check("wrmiss_ready", cache2cpu_ready, 1'b1);
    check("wrmiss_hit", cache2cpu_hit, 1'b0);
    check("wrmiss_cpu_data", cache2cpu_data, 32'h0);

    req(1'b0, 32'h0000_5678, 32'h0);
    check("rd5678_hit", cache2cpu_hit, 1'b1);
    check("rd5678_data", cache2cpu_data, 32'hCAFE_BABE);
    req(1'b0, 32'h0000_5674, 32'h0);
    check("rd5674_ready", cache2cpu_ready, 1'b1);
    check("rd5674_data", cache2cpu_data, 32'hFEED_FACE);

    // Write hit: no memory traffic.
    req(1'b1, 32'h0000_5678, 32'hDEAD_BEEF);
    check("wrhit_ready", cache2cpu_ready, 1'b1);
    check("wrhit_hit", cache2cpu_hit, 1'b1);
    check("wrhit_no_mem", cache2mem_valid, 1'b0);

    // Dirty eviction: same index 0x67, different tag.
    req(1'b0, 32'h0001_5678, 32'h0);
    check("evict_lookup_ready", cache2cpu_ready, 1'b0);
    @(negedge clk);
    wait_mem("evict_wb", 1'b1, 32'h0000_5670);
    check("evict_wb_data", cache2mem_data,
          128'hFEEDFACE_DEADBEEF_FEEDFACE_FEEDFACE);
    @(negedge clk);
    check("evict_wb_held", cache2mem_valid, 1'b1);
    check("evict_wb_held_addr", cache2mem_addr, 32'h0000_5670);
    respond(128'h0);
    wait_mem("evict_alloc", 1'b0, 32'h0001_5670);
    respond(128'h01234567_89ABCDEF_00112233_44556677);
    check("evict_ready", cache2cpu_ready, 1'b1);
    check("evict_hit", cache2cpu_hit, 1'b0);
    check("evict_data", cache2cpu_data, 32'h89AB_CDEF);

    // Reset in the middle of an allocate.
    req(1'b0, 32'h0000_2234, 32'h0);
    @(negedge clk);
    wait_mem("rstmid_alloc", 1'b0, 32'h0000_2230);
    r = 1'b0;
    #1;
    check("rstmid_mem_valid", cache2mem_valid, 1'b0);
    check("rstmid_mem_addr", cache2mem_addr, 32'h0);
    @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    check("rstmid_idle", cache2mem_valid, 1'b0);

    // Line 0x23 was valid before reset; it must now miss.
    req(1'b0, 32'h0000_1234, 32'h0);
    check("postrst_lookup_ready", cache2cpu_ready, 1'b0);
    @(negedge clk);
    wait_mem("postrst_alloc", 1'b0, 32'h0000_1230);
    respond({32'h4, 32'h3, 32'h2, 32'h1});
    check("postrst_ready", cache2cpu_ready, 1'b1);
    check("postrst_hit", cache2cpu_hit, 1'b0);
    check("postrst_data", cache2cpu_data, 32'h2);

`ifdef DM_CACHE_PERF_EN
    @(negedge clk);
    check("perf_hit_cnt", hit_cnt, 32'd0);
    check("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
